// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder sequencing one full_adder cell; optional subtract via SERIAL_ADDER_SUB_EN

// One-bit full-adder datapath cell shared by every bit position.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// Controller: loads operands on accept, walks them LSB first through the
// cell with a registered carry, and publishes {cout,sum} with a done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // Counter must hold 0..WIDTH-1; keep at least one bit so WIDTH=1 works.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;

    // The single shared cell always looks at the current LSBs and carry.
    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit i sits at index i.
    assign w_res_next = WIDTH'({w_fa_sum, r_res} >> 1);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract is a + ~b + 1: invert B and force the initial carry to one.
    assign w_b_load     = i_sub ? ~i_b : i_b;
    assign w_carry_load = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_load     = i_b;
    assign w_carry_load = i_cin;
`endif

    // Sequencer: IDLE accepts, RUN processes one bit per edge, DONE pulses once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_a     <= i_a;
                        r_b     <= w_b_load;
                        r_carry <= w_carry_load;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // start is deliberately not looked at here.
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_fa_cout;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state <= S_DONE;
                        r_sum   <= w_res_next;
                        r_cout  <= w_fa_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances)
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       busy1, done1, sum1, cout1;

    int passed = 0;
    int total  = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (sub),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .i_cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (1'b0),
`endif
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
        .o_cout  (cout1)
    );

    always @(negedge clk) begin
        if ((busy && done) || (busy1 && done1)) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on WIDTH+1 bits.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns at #1 after the edge leaving DONE.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input logic xs,
                          output logic [7:0] rs, output logic rc, output int lat, output int bcnt);
        start = 1'b1; a = xa; b = xb; cin = xc; sub = xs;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        bcnt = busy ? 1 : 0;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (done || lat >= 40) break;
            if (busy) bcnt++;
        end
        rs = sum; rc = cout;
        @(posedge clk); #1;
        check("done_single_cycle", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    initial begin
        vec_t       tbl[6];
        logic [7:0] rs;
        logic       rc;
        logic [8:0] exp;
        int         lat, bcnt, bad, cyc;
        int         dq[$];

        tbl[0] = '{8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        // Reset with random activity on the inputs: outputs stay at zero.
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = $urandom; a = $urandom; b = $urandom; cin = $urandom;
            start1 = $urandom; a1 = $urandom; b1 = $urandom; cin1 = $urandom;
            if (busy || done || sum != 0 || cout || busy1 || done1) bad++;
        end
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_sum", {24'd0, sum}, 0);
        check("reset_cout", {31'd0, cout}, 0);
        check("reset_no_toggle", bad, 0);
        start = 0; start1 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, rs, rc, lat, bcnt);
            check($sformatf("tbl%0d_sum", i), {24'd0, rs}, {24'd0, tbl[i].sum});
            check($sformatf("tbl%0d_cout", i), {31'd0, rc}, {31'd0, tbl[i].cout});
            check($sformatf("tbl%0d_latency", i), lat, 8);
            check($sformatf("tbl%0d_busy_cycles", i), bcnt, 8);
        end

        // Random operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            logic       rcn;
            ra = $urandom; rb = $urandom; rcn = $urandom;
            run_op(ra, rb, rcn, 1'b0, rs, rc, lat, bcnt);
            exp = model(ra, rb, rcn, 1'b0);
            check($sformatf("rand%0d_result", i), {23'd0, rc, rs}, {23'd0, exp});
        end

        // start pulsed mid-run with a different operand is ignored.
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1; start = 1'b1; a = 8'h12;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ignore_start_sum", {24'd0, sum}, 32'h02);
        check("ignore_start_cout", {31'd0, cout}, 0);
        bad = 0;
        repeat (4) begin @(posedge clk); #1; if (busy || done) bad++; end
        check("ignore_start_not_queued", bad, 0);

        // start held high: one done every WIDTH+2 cycles.
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk); #1;
            if (done) dq.push_back(cyc);
        end
        start = 1'b0;
        check("held_start_done_count", (dq.size() >= 4) ? 1 : 0, 1);
        for (int i = 1; i < dq.size(); i++)
            check($sformatf("held_start_period%0d", i), dq[i] - dq[i-1], 10);
        lat = 0;
        while ((busy || done) && lat < 20) begin @(posedge clk); #1; lat++; end
        check("held_start_drain", {30'd0, busy, done}, 0);

        // Reset after bit 4 of AA+55 aborts with no done.
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_sum", {23'd0, cout, sum}, 0);
        bad = 0;
        repeat (2) begin @(posedge clk); #1; if (done) bad++; end
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (done || busy || sum != 0) bad++; end
        check("midreset_no_done", bad, 0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, rs, rc, lat, bcnt);
        check("after_reset_sum", {23'd0, rc, rs}, 32'h003);

        // WIDTH=1 exhaustive sweep against the full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            int t;
            start1 = 1'b1; a1 = i[2]; b1 = i[1]; cin1 = i[0];
            @(posedge clk); #1;
            start1 = 1'b0;
            check($sformatf("w1_%0d_busy", i), {31'd0, busy1}, 1);
            @(posedge clk); #1;
            t = i[2] + i[1] + i[0];
            check($sformatf("w1_%0d_done", i), {30'd0, busy1, done1}, 32'd1);
            check($sformatf("w1_%0d_result", i), {30'd0, cout1, sum1}, t);
            @(posedge clk); #1;
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h0A, 8'h03, 1'b0, 1'b1, rs, rc, lat, bcnt);
        check("sub_0a_03", {23'd0, rc, rs}, 32'h107);
        run_op(8'h03, 8'h05, 1'b1, 1'b1, rs, rc, lat, bcnt);
        check("sub_03_05", {23'd0, rc, rs}, 32'h0FE);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra, rb;
            logic       rcn, rsb;
            ra = $urandom; rb = $urandom; rcn = $urandom; rsb = $urandom;
            run_op(ra, rb, rcn, rsb, rs, rc, lat, bcnt);
            exp = model(ra, rb, rcn, rsb);
            check($sformatf("sub_rand%0d", i), {23'd0, rc, rs}, {23'd0, exp});
        end
`endif

        check("busy_done_exclusive", overlap, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
